// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter with a small TX FIFO.
// Registers: TXDATA (+0x0, write), STATUS (+0x4, read), BAUDDIV (+0x8, read/write).
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h1000_0000,
  parameter logic [15:0] DIV_RESET  = 16'd434,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemWrite,
  input  logic        MemRead,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  input  logic [2:0]  funct3,
  output logic [31:0] read_data,
  output logic        tx,
  output logic        irq
);
  localparam int         PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [4:0] DEPTH = 5'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           r_state, w_stateNext;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [4:0]       r_count, w_countNext;
  logic             r_overflow;
  logic [15:0]      r_div, w_divEff;
  logic [7:0]       r_shift, w_shiftNext;
  logic [2:0]       r_bitCnt, w_bitCntNext;
  logic [15:0]      r_period, w_periodNext;
  logic [15:0]      r_cnt, w_cntNext;
  logic             r_tx, w_txNext, r_irq;
  logic             w_hit, w_selTx, w_selStatus, w_selDiv;
  logic             w_full, w_empty, w_busy, w_wrTx, w_push, w_pop, w_ovfSet;
  logic             w_periodEnd;
  logic             w_unused;

  assign w_unused = ^{funct3, address[1:0], write_data[31:16]};

  assign w_hit       = (address[31:4] == BASE_ADDR[31:4]);
  assign w_selTx     = w_hit && (address[3:2] == 2'd0);
  assign w_selStatus = w_hit && (address[3:2] == 2'd1);
  assign w_selDiv    = w_hit && (address[3:2] == 2'd2);

  assign w_full  = (r_count == DEPTH);
  assign w_empty = (r_count == 5'd0);
  assign w_busy  = (r_state != IDLE);

  // A pop in the same cycle frees a slot, so a store to a full FIFO still lands.
  assign w_wrTx   = MemWrite && w_selTx;
  assign w_push   = w_wrTx && (!w_full || w_pop);
  assign w_ovfSet = w_wrTx && w_full && !w_pop;

  assign w_divEff    = (r_div == 16'd0) ? 16'd1 : r_div;
  assign w_periodEnd = (r_cnt == r_period - 16'd1);

  always_comb begin
    w_countNext = r_count;
    case ({w_push, w_pop})
      2'b10:   w_countNext = r_count + 5'd1;
      2'b01:   w_countNext = r_count - 5'd1;
      default: w_countNext = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= write_data[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= 5'd0;
      r_overflow <= 1'b0;
      r_div      <= DIV_RESET;
    end else begin
      if (w_push) r_wptr <= r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= r_rptr + PTR_W'(1);
      r_count <= w_countNext;
      if (w_ovfSet) r_overflow <= 1'b1;
      else if (MemRead && w_selStatus) r_overflow <= 1'b0;
      if (MemWrite && w_selDiv) r_div <= write_data[15:0];
    end
  end

  // Frame sequencing; the bit period is latched whenever a new frame is popped.
  always_comb begin
    w_stateNext  = r_state;
    w_txNext     = r_tx;
    w_pop        = 1'b0;
    w_shiftNext  = r_shift;
    w_bitCntNext = r_bitCnt;
    w_cntNext    = r_cnt;
    w_periodNext = r_period;
    case (r_state)
      IDLE: begin
        w_txNext = 1'b1;
        if (!w_empty) begin
          w_pop        = 1'b1;
          w_shiftNext  = r_mem[r_rptr];
          w_bitCntNext = 3'd0;
          w_cntNext    = 16'd0;
          w_periodNext = w_divEff;
          w_stateNext  = START;
          w_txNext     = 1'b0;
        end
      end
      START: begin
        if (w_periodEnd) begin
          w_cntNext   = 16'd0;
          w_stateNext = DATA;
          w_txNext    = r_shift[0];
        end else begin
          w_cntNext = r_cnt + 16'd1;
        end
      end
      DATA: begin
        if (w_periodEnd) begin
          w_cntNext = 16'd0;
          if (r_bitCnt == 3'd7) begin
            w_stateNext = STOP;
            w_txNext    = 1'b1;
          end else begin
            w_shiftNext  = {1'b0, r_shift[7:1]};
            w_bitCntNext = r_bitCnt + 3'd1;
            w_txNext     = r_shift[1];
          end
        end else begin
          w_cntNext = r_cnt + 16'd1;
        end
      end
      STOP: begin
        if (w_periodEnd) begin
          w_cntNext = 16'd0;
          if (!w_empty) begin
            w_pop        = 1'b1;
            w_shiftNext  = r_mem[r_rptr];
            w_bitCntNext = 3'd0;
            w_periodNext = w_divEff;
            w_stateNext  = START;
            w_txNext     = 1'b0;
          end else begin
            w_stateNext = IDLE;
            w_txNext    = 1'b1;
          end
        end else begin
          w_cntNext = r_cnt + 16'd1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_tx     <= 1'b1;
      r_irq    <= 1'b1;
      r_shift  <= 8'd0;
      r_bitCnt <= 3'd0;
      r_cnt    <= 16'd0;
      r_period <= 16'd0;
    end else begin
      r_state  <= w_stateNext;
      r_tx     <= w_txNext;
      r_irq    <= (w_countNext == 5'd0) && (w_stateNext == IDLE);
      r_shift  <= w_shiftNext;
      r_bitCnt <= w_bitCntNext;
      r_cnt    <= w_cntNext;
      r_period <= w_periodNext;
    end
  end

  always_comb begin
    read_data = 32'd0;
    if (MemRead) begin
      if (w_selStatus)   read_data = {23'd0, r_count, r_overflow, w_busy, w_empty, w_full};
      else if (w_selDiv) read_data = {16'd0, r_div};
    end
  end

  assign tx  = r_tx;
  assign irq = r_irq;
endmodule

// File: tb/tb_mmio_uart_tx.sv
// Self-checking bench for mmio_uart_tx: directed scenarios plus randomized frames
// compared against a frame-level model of the expected serial line.
module tb_mmio_uart_tx;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam logic [31:0] A_TX  = BASE;
  localparam logic [31:0] A_ST  = BASE + 32'h4;
  localparam logic [31:0] A_DIV = BASE + 32'h8;

  logic        clk        = 1'b0;
  logic        rst_n      = 1'b1;
  logic        MemWrite   = 1'b0;
  logic        MemRead    = 1'b0;
  logic [31:0] address    = 32'd0;
  logic [31:0] write_data = 32'd0;
  logic [2:0]  funct3     = 3'b010;
  logic [31:0] read_data;
  logic        tx, irq;

  int testsRun = 0;
  int testsFailed = 0;

  logic       lineLog[$];
  int         captureDelay;
  bit         captureTimeout;
  int         firstBad;
  logic [7:0] expBytes[$];
  int         expPeriods[$];

  mmio_uart_tx #(.BASE_ADDR(BASE), .DIV_RESET(16'd434), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .MemWrite(MemWrite), .MemRead(MemRead),
    .address(address), .write_data(write_data), .funct3(funct3),
    .read_data(read_data), .tx(tx), .irq(irq)
  );

  always #5 clk = ~clk;

  // Core store: driven mid-low-phase, takes effect at the following rising edge.
  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    address = a; write_data = d; MemWrite = 1'b1;
    @(posedge clk); #1;
    MemWrite = 1'b0; address = 32'd0;
  endtask

  task automatic busRead(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    address = a; MemRead = 1'b1;
    #1 d = read_data;
    @(posedge clk); #1;
    MemRead = 1'b0; address = 32'd0;
  endtask

  // Waits (bounded) for the line to drop, then records n samples, one per cycle.
  task automatic captureLine(input int n);
    lineLog.delete();
    captureTimeout = 1'b0;
    captureDelay = 0;
    while (1) begin
      @(posedge clk); #1;
      captureDelay++;
      if (tx === 1'b0) break;
      if (captureDelay >= 400) begin
        captureTimeout = 1'b1;
        return;
      end
    end
    lineLog.push_back(tx);
    for (int i = 1; i < n; i++) begin
      @(posedge clk); #1;
      lineLog.push_back(tx);
    end
  endtask

  // Expected line level k cycles after the first start bit, from the frame list.
  function automatic logic modelLine(input int k);
    int t = k;
    for (int f = 0; f < expBytes.size(); f++) begin
      int len = 10 * expPeriods[f];
      if (t < len) begin
        int idx = t / expPeriods[f];
        if (idx == 0) return 1'b0;
        if (idx == 9) return 1'b1;
        return expBytes[f][idx-1];
      end
      t -= len;
    end
    return 1'b1;
  endfunction

  function automatic int lineErrors();
    int e = 0;
    firstBad = -1;
    for (int k = 0; k < lineLog.size(); k++) begin
      if (lineLog[k] !== modelLine(k)) begin
        e++;
        if (firstBad < 0) firstBad = k;
      end
    end
    return e;
  endfunction

  task automatic test_reset();
    logic [31:0] d;
    #2 rst_n = 1'b0;
    #21;
    testsRun++; if (tx !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_tx: got %b want 1", tx); end
    testsRun++; if (irq !== 1'b1) begin testsFailed++; $display("[TB] FAIL reset_irq: got %b want 1", irq); end
    address = A_ST; MemRead = 1'b1; #1;
    testsRun++; if (read_data !== 32'h2) begin testsFailed++; $display("[TB] FAIL reset_status_held: got %h want 00000002", read_data); end
    MemRead = 1'b0; address = 32'd0;
    @(negedge clk); rst_n = 1'b1;
    busRead(A_DIV, d);
    testsRun++; if (d !== 32'h1B2) begin testsFailed++; $display("[TB] FAIL reset_div: got %h want 000001b2", d); end
    busRead(A_DIV | 32'h3, d);
    testsRun++; if (d !== 32'h1B2) begin testsFailed++; $display("[TB] FAIL div_low_bits_ignored: got %h want 000001b2", d); end
    busRead(A_ST, d);
    testsRun++; if (d !== 32'h2) begin testsFailed++; $display("[TB] FAIL reset_status: got %h want 00000002", d); end
    busRead(A_TX, d);
    testsRun++; if (d !== 32'h0) begin testsFailed++; $display("[TB] FAIL txdata_read: got %h want 0", d); end
    busRead(BASE + 32'hC, d);
    testsRun++; if (d !== 32'h0) begin testsFailed++; $display("[TB] FAIL unmapped_0xC: got %h want 0", d); end
    busRead(BASE + 32'h18, d);
    testsRun++; if (d !== 32'h0) begin testsFailed++; $display("[TB] FAIL unmapped_outside: got %h want 0", d); end
    @(negedge clk); address = A_DIV; MemRead = 1'b0; #1;
    testsRun++; if (read_data !== 32'h0) begin testsFailed++; $display("[TB] FAIL read_no_strobe: got %h want 0", read_data); end
    address = 32'd0;
  endtask

  task automatic test_frame55();
    int errs;
    busWrite(A_DIV, 32'd4);
    expBytes.delete(); expPeriods.delete();
    expBytes.push_back(8'h55); expPeriods.push_back(4);
    busWrite(A_TX, 32'h55);
    testsRun++; if (tx !== 1'b1) begin testsFailed++; $display("[TB] FAIL f55_before_start: tx got %b want 1", tx); end
    testsRun++; if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL f55_irq_queued: got %b want 0", irq); end
    captureLine(40);
    testsRun++; if (captureTimeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL f55_timeout: no start bit seen"); end
    testsRun++; if (captureDelay !== 1) begin testsFailed++; $display("[TB] FAIL f55_latency: got %0d cycles want 1", captureDelay); end
    errs = lineErrors();
    testsRun++; if (errs !== 0) begin testsFailed++; $display("[TB] FAIL f55_line: %0d bad samples (first %0d) want 0", errs, firstBad); end
    testsRun++; if (irq !== 1'b0) begin testsFailed++; $display("[TB] FAIL f55_irq_in_stop: got %b want 0", irq); end
    @(posedge clk); #1;
    testsRun++; if (irq !== 1'b1 || tx !== 1'b1) begin testsFailed++; $display("[TB] FAIL f55_idle_after: irq=%b tx=%b want 1/1", irq, tx); end
  endtask

  task automatic test_div_zero();
    logic [31:0] d;
    int errs;
    busWrite(A_DIV, 32'd0);
    busRead(A_DIV, d);
    testsRun++; if (d !== 32'h0) begin testsFailed++; $display("[TB] FAIL div0_readback: got %h want 0", d); end
    expBytes.delete(); expPeriods.delete();
    expBytes.push_back(8'hFF); expPeriods.push_back(1);
    busWrite(A_TX, 32'hFF);
    captureLine(10);
    testsRun++; if (captureDelay !== 1) begin testsFailed++; $display("[TB] FAIL div0_latency: got %0d cycles want 1", captureDelay); end
    errs = lineErrors();
    testsRun++; if (errs !== 0) begin testsFailed++; $display("[TB] FAIL div0_line: %0d bad samples (first %0d) want 0", errs, firstBad); end
    @(posedge clk); #1;
    testsRun++; if (irq !== 1'b1) begin testsFailed++; $display("[TB] FAIL div0_irq: got %b want 1", irq); end
  endtask

  task automatic test_overflow();
    logic [7:0]  b[6];
    logic [31:0] s1, s2;
    int errs;
    busWrite(A_DIV, 32'd2);
    expBytes.delete(); expPeriods.delete();
    for (int i = 0; i < 6; i++) begin
      b[i] = 8'($urandom);
      if (i < 5) begin expBytes.push_back(b[i]); expPeriods.push_back(2); end
    end
    fork
      begin
        for (int i = 0; i < 6; i++) busWrite(A_TX, {24'd0, b[i]});
        busRead(A_ST, s1);
        busRead(A_ST, s2);
      end
      captureLine(100);
    join
    testsRun++; if (s1 !== 32'h4D) begin testsFailed++; $display("[TB] FAIL ovf_status_first: got %h want 0000004d", s1); end
    testsRun++; if (s2 !== 32'h45) begin testsFailed++; $display("[TB] FAIL ovf_status_cleared: got %h want 00000045", s2); end
    testsRun++; if (captureTimeout !== 1'b0) begin testsFailed++; $display("[TB] FAIL ovf_timeout: no start bit seen"); end
    errs = lineErrors();
    testsRun++; if (errs !== 0) begin testsFailed++; $display("[TB] FAIL ovf_line: %0d bad samples (first %0d) want 0", errs, firstBad); end
    @(posedge clk); #1;
    testsRun++; if (irq !== 1'b1 || tx !== 1'b1) begin testsFailed++; $display("[TB] FAIL ovf_idle_after: irq=%b tx=%b want 1/1", irq, tx); end
  endtask

  task automatic test_full_pop();
    logic [7:0]  b[6];
    logic [31:0] s1, s2;
    int errs;
    busWrite(A_DIV, 32'd2);
    expBytes.delete(); expPeriods.delete();
    for (int i = 0; i < 6; i++) begin
      b[i] = 8'($urandom);
      expBytes.push_back(b[i]); expPeriods.push_back(2);
    end
    fork
      begin
        for (int i = 0; i < 5; i++) busWrite(A_TX, {24'd0, b[i]});
        busRead(A_ST, s1);
        repeat (15) @(posedge clk);
        busWrite(A_TX, {24'd0, b[5]});
        busRead(A_ST, s2);
      end
      captureLine(120);
    join
    testsRun++; if (s1 !== 32'h45) begin testsFailed++; $display("[TB] FAIL fullpop_status_full: got %h want 00000045", s1); end
    testsRun++; if (s2 !== 32'h45) begin testsFailed++; $display("[TB] FAIL fullpop_status_after: got %h want 00000045", s2); end
    errs = lineErrors();
    testsRun++; if (errs !== 0 || captureTimeout) begin testsFailed++; $display("[TB] FAIL fullpop_line: %0d bad samples (first %0d) timeout=%b want 0", errs, firstBad, captureTimeout); end
    @(posedge clk); #1;
    testsRun++; if (irq !== 1'b1) begin testsFailed++; $display("[TB] FAIL fullpop_irq: got %b want 1", irq); end
  endtask

  task automatic test_baud_change();
    logic [31:0] d;
    int errs;
    busWrite(A_DIV, 32'd4);
    expBytes.delete(); expPeriods.delete();
    expBytes.push_back(8'hA5); expPeriods.push_back(4);
    expBytes.push_back(8'h3C); expPeriods.push_back(8);
    fork
      begin
        busWrite(A_TX, 32'hA5);
        busWrite(A_TX, 32'h3C);
        repeat (8) @(posedge clk);
        busWrite(A_DIV, 32'd8);
      end
      captureLine(120);
    join
    errs = lineErrors();
    testsRun++; if (errs !== 0 || captureTimeout) begin testsFailed++; $display("[TB] FAIL baudchg_line: %0d bad samples (first %0d) timeout=%b want 0", errs, firstBad, captureTimeout); end
    busRead(A_DIV, d);
    testsRun++; if (d !== 32'h8) begin testsFailed++; $display("[TB] FAIL baudchg_div: got %h want 00000008", d); end
    testsRun++; if (irq !== 1'b1) begin testsFailed++; $display("[TB] FAIL baudchg_irq: got %b want 1", irq); end
  endtask

  task automatic test_random();
    logic [7:0] b[5];
    int div, n, errs;
    for (int it = 0; it < 4; it++) begin
      div = $urandom_range(0, 5);
      n   = $urandom_range(1, 5);
      busWrite(A_DIV, div);
      expBytes.delete(); expPeriods.delete();
      for (int i = 0; i < n; i++) begin
        b[i] = 8'($urandom);
        expBytes.push_back(b[i]);
        expPeriods.push_back((div == 0) ? 1 : div);
      end
      fork
        for (int i = 0; i < n; i++) busWrite(A_TX | 32'($urandom_range(0, 3)), {24'($urandom), b[i]});
        captureLine(10 * ((div == 0) ? 1 : div) * n);
      join
      errs = lineErrors();
      testsRun++; if (errs !== 0 || captureTimeout) begin testsFailed++; $display("[TB] FAIL random%0d_line div=%0d n=%0d: %0d bad samples (first %0d) timeout=%b want 0", it, div, n, errs, firstBad, captureTimeout); end
      @(posedge clk); #1;
      testsRun++; if (irq !== 1'b1 || tx !== 1'b1) begin testsFailed++; $display("[TB] FAIL random%0d_idle: irq=%b tx=%b want 1/1", it, irq, tx); end
    end
  endtask

  task automatic test_reset_midframe();
    logic [31:0] d;
    int lows;
    busWrite(A_DIV, 32'd4);
    busWrite(A_TX, 32'h00);
    busWrite(A_TX, 32'h11);
    busWrite(A_TX, 32'h22);
    repeat (16) @(posedge clk);
    #3;
    testsRun++; if (tx !== 1'b0) begin testsFailed++; $display("[TB] FAIL midrst_bit3_low: got %b want 0", tx); end
    rst_n = 1'b0;
    #1;
    testsRun++; if (tx !== 1'b1 || irq !== 1'b1) begin testsFailed++; $display("[TB] FAIL midrst_async: tx=%b irq=%b want 1/1", tx, irq); end
    address = A_ST; MemRead = 1'b1; #1;
    testsRun++; if (read_data !== 32'h2) begin testsFailed++; $display("[TB] FAIL midrst_status: got %h want 00000002", read_data); end
    MemRead = 1'b0; address = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 60; i++) begin
      @(posedge clk); #1;
      if (tx !== 1'b1) lows++;
    end
    testsRun++; if (lows !== 0) begin testsFailed++; $display("[TB] FAIL midrst_no_resume: %0d low samples want 0", lows); end
    busRead(A_ST, d);
    testsRun++; if (d !== 32'h2) begin testsFailed++; $display("[TB] FAIL midrst_status_after: got %h want 00000002", d); end
    busRead(A_DIV, d);
    testsRun++; if (d !== 32'h1B2) begin testsFailed++; $display("[TB] FAIL midrst_div: got %h want 000001b2", d); end
  endtask

  // Runs every scenario in order, then prints the summary.
  initial begin
    test_reset();
    test_frame55();
    test_div_zero();
    test_overflow();
    test_full_pop();
    test_baud_change();
    test_random();
    test_reset_midframe();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  initial begin
    #500_000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end
endmodule
